v810_bus_arb: RTL and testbench
===============================

Name: v810_bus_arb

Overview:
Arbitrates the v810_exec split instruction-fetch and data ports onto one external 32-bit memory bus. Each access runs a T1/T2(+wait) bus cycle with READYn wait-state insertion and a timeout. Sits between v810_exec and system memory or peripherals. Owns the external bus signals ST, MRQn, RW, BEn and BCYSTn.

Parameters:
TIMEOUT, 15, maximum wait cycles in T2 before forced termination with BUSERR (1..255).

Ports:
CLK  in  1  system clock
RESn  in  1  asynchronous active-low reset
CE  in  1  clock enable; all state frozen when 0
I_REQ  in  1  fetch request; held with I_A until I_ACK
I_A  in  32  fetch address
I_D  out  32  fetch data; valid while I_ACK=1
I_ACK  out  1  one-cycle fetch completion pulse
D_REQ  in  1  data request; held with D_A/D_WR/D_BEn/D_DO until D_ACK
D_A  in  32  data address
D_WR  in  1  1 = write
D_BEn  in  4  data byte enables, active low
D_DO  in  32  write data from core
D_DI  out  32  read data to core; valid while D_ACK=1
D_ACK  out  1  one-cycle data completion pulse
BUSERR  out  1  pulses with the ACK of a timed-out access
A  out  32  bus address, {addr[31:2],2'b00}
DO  out  32  bus write data
DI  in  32  bus read data
BEn  out  4  bus byte enables
ST  out  2  bus status (package codes)
MRQn  out  1  memory request, active low
RW  out  1  1 = read, 0 = write
BCYSTn  out  1  bus cycle start, low in T1 only
READYn  in  1  bus ready, sampled at each T2 edge

Behaviour:
- Reset (async, RESn=0): state IDLE; MRQn=1, BCYSTn=1, RW=1, BEn=4'hF, A=0, DO=0, ST=ST_IDLE, I_ACK=D_ACK=BUSERR=0, I_D=D_DI=0, wait counter 0, RR pointer = data. Assertion mid-cycle aborts the cycle. No ACK is issued for it.
- Register update requires CE=1; with CE=0 all state and outputs hold.
- States: IDLE, T1, T2.
- IDLE:
  - Arbitrate. D_REQ wins over I_REQ (fixed priority).
  - On grant, latch A, BEn, RW, DO and ST at the edge, then go to T1.
  - Fetch: RW=1, BEn=4'h0, ST=ST_IFETCH.
  - Data: RW=~D_WR, BEn=D_BEn, ST=ST_DATA, DO=D_DO when writing.
- T1: MRQn=0, BCYSTn=0; one cycle, then T2.
- T2:
  - MRQn=0, BCYSTn=1.
  - At each edge, READYn=0 completes the access. On a read, DI is registered into I_D or D_DI. The owner's ACK goes high for exactly the next cycle.
  - READYn=1: increment wait counter. If the counter equals TIMEOUT, complete anyway with BUSERR=1 alongside the ACK; read data returns 0; a write is dropped.
- At completion, arbitrate with the just-served requester masked. If the other requester is pending, go straight to T1 (back-to-back, MRQn stays 0). Otherwise go to IDLE: MRQn=1, ST=ST_IDLE, RW=1, BEn=4'hF.
- Minimum latency: REQ high at edge k → T1 in cycle k+1 → T2 in cycle k+2 → ACK high in cycle k+3 (zero wait states). Each wait cycle adds 1.
- Simultaneous I_REQ and D_REQ in IDLE: data first, then fetch back-to-back.
- Request inputs are sampled only at grant. Later changes before ACK are ignored.

Optional Feature:
V810_BUS_ARB_RR_EN:
- Defined: round-robin. When both requesters are pending at an arbitration point, the one not granted last wins. The masking rule at completion still applies.
- Undefined: fixed data-over-fetch priority, and the RR pointer logic is absent.

Decomposition:
- Package v810_bus_pkg:
  - state enum bus_state_t {BS_IDLE, BS_T1, BS_T2}
  - ST codes: ST_IDLE=2'b00, ST_IFETCH=2'b10, ST_DATA=2'b11
  - grant enum {GNT_I, GNT_D}
  - default TIMEOUT
- Sub-module v810_bus_wait_timer: clears at T1, counts while READYn=1 in T2, asserts expire at TIMEOUT.

Test Plan:
1. Reset, then I_REQ with I_A=0x104 and DI=0x12345678, READYn=0 → T1 at cycle 1, I_ACK in cycle 3, I_D=0x12345678, A=0x104, ST=2'b10, BEn=0.
2. D_REQ write with D_A=0x70, D_DO=9, D_BEn=4'h0, READYn=0 → RW=0, DO=9, D_ACK after 3 cycles; memory word 0x70>>2 = 9.
3. I_REQ and D_REQ in the same cycle → data cycle first, then fetch T1 immediately with MRQn continuously 0; D_ACK then I_ACK, 2 cycles apart.
4. READYn held high 3 extra T2 cycles → ACK delayed by exactly 3 cycles, BUSERR=0.
5. READYn stuck high, TIMEOUT=15 → ACK and BUSERR together after 15 wait cycles, D_DI=0, FSM returns to IDLE.
6. RESn low during T2 → MRQn=1 immediately, no ACK. After release, a new I_REQ completes normally. With V810_BUS_ARB_RR_EN, repeated dual requests alternate grants D, I, D, I.

Source files
------------

// File: rtl/v810_bus_pkg.sv
// Shared types and codes for the v810 external bus arbiter.
package v810_bus_pkg;

    typedef enum logic [1:0] {
        BS_IDLE = 2'd0,
        BS_T1   = 2'd1,
        BS_T2   = 2'd2
    } bus_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_IFETCH = 2'b10;
    localparam logic [1:0] ST_DATA   = 2'b11;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/v810_bus_arb_wait_timer.sv
// v810_bus_wait_timer: counts T2 wait states, expires when the count reaches TIMEOUT.
// Latency: expire is combinational from the registered count. Backpressure: none; frozen while ce=0.
// Waits: cleared in T1, one increment per T2 edge with ready_n high.
module v810_bus_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic clr,
    input  logic t2,
    input  logic ready_n,
    output logic expire
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    logic [7:0] cnt;

    assign expire = t2 && ready_n && (cnt == TO_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (ce) begin
            if (clr) begin
                cnt <= 8'd0;
            end else if (t2 && ready_n && !expire) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/v810_bus_arb.sv
// v810_bus_arb: merges the fetch and data ports onto one T1/T2 bus; optional V810_BUS_ARB_RR_EN selects round-robin.
// Latency: REQ at edge k -> T1 k+1 -> T2 k+2 -> ACK k+3, plus one cycle per READYn wait; TIMEOUT ends with BUSERR.
// Backpressure: requesters hold REQ until their ACK; READYn high stretches T2; CE=0 freezes everything.
module v810_bus_arb
    import v810_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        I_REQ,
    input  logic [31:0] I_A,
    output logic [31:0] I_D,
    output logic        I_ACK,
    input  logic        D_REQ,
    input  logic [31:0] D_A,
    input  logic        D_WR,
    input  logic [3:0]  D_BEn,
    input  logic [31:0] D_DO,
    output logic [31:0] D_DI,
    output logic        D_ACK,
    output logic        BUSERR,
    output logic [31:0] A,
    output logic [31:0] DO,
    input  logic [31:0] DI,
    output logic [3:0]  BEn,
    output logic [1:0]  ST,
    output logic        MRQn,
    output logic        RW,
    output logic        BCYSTn,
    input  logic        READYn
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    bus_state_t  state, state_nx;
    grant_t      owner, owner_nx, gsel;
    logic        grant, expire;
    logic [31:0] a_nx, do_nx, id_nx, ddi_nx;
    logic [3:0]  ben_nx;
    logic [1:0]  st_nx;
    logic        rw_nx, mrq_nx, bcyst_nx, iack_nx, dack_nx, berr_nx;
`ifdef V810_BUS_ARB_RR_EN
    grant_t      rr_pri, rr_nx;
`endif

    v810_bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (RESn),
        .ce      (CE),
        .clr     (state == BS_T1),
        .t2      (state == BS_T2),
        .ready_n (READYn),
        .expire  (expire)
    );

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        a_nx     = A;
        do_nx    = DO;
        ben_nx   = BEn;
        st_nx    = ST;
        rw_nx    = RW;
        mrq_nx   = MRQn;
        bcyst_nx = BCYSTn;
        id_nx    = I_D;
        ddi_nx   = D_DI;
        iack_nx  = 1'b0;
        dack_nx  = 1'b0;
        berr_nx  = 1'b0;
        grant    = 1'b0;
        gsel     = GNT_D;
`ifdef V810_BUS_ARB_RR_EN
        rr_nx    = rr_pri;
`endif
        case (state)
            BS_IDLE: begin
                grant = I_REQ | D_REQ;
`ifdef V810_BUS_ARB_RR_EN
                if (I_REQ && D_REQ) gsel = rr_pri;
                else                gsel = D_REQ ? GNT_D : GNT_I;
`else
                gsel  = D_REQ ? GNT_D : GNT_I;
`endif
            end
            BS_T1: begin
                state_nx = BS_T2;
                bcyst_nx = 1'b1;
            end
            BS_T2: begin
                if (!READYn || expire) begin
                    berr_nx = expire;
                    // Only the requester that was not just served may take the bus back-to-back.
                    if (owner == GNT_I) begin
                        iack_nx = 1'b1;
                        id_nx   = expire ? 32'd0 : DI;
                        grant   = D_REQ;
                        gsel    = GNT_D;
                    end else begin
                        dack_nx = 1'b1;
                        if (RW) ddi_nx = expire ? 32'd0 : DI;
                        grant   = I_REQ;
                        gsel    = GNT_I;
                    end
                    if (!grant) begin
                        state_nx = BS_IDLE;
                        mrq_nx   = 1'b1;
                        st_nx    = ST_IDLE;
                        rw_nx    = 1'b1;
                        ben_nx   = 4'hF;
                    end
                end
            end
            default: state_nx = BS_IDLE;
        endcase

        if (grant) begin
            state_nx = BS_T1;
            owner_nx = gsel;
            mrq_nx   = 1'b0;
            bcyst_nx = 1'b0;
`ifdef V810_BUS_ARB_RR_EN
            rr_nx    = (gsel == GNT_D) ? GNT_I : GNT_D;
`endif
            if (gsel == GNT_D) begin
                a_nx   = D_A & WORD_MASK;
                ben_nx = D_BEn;
                rw_nx  = ~D_WR;
                st_nx  = ST_DATA;
                if (D_WR) do_nx = D_DO;
            end else begin
                a_nx   = I_A & WORD_MASK;
                ben_nx = 4'h0;
                rw_nx  = 1'b1;
                st_nx  = ST_IFETCH;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state  <= BS_IDLE;
            owner  <= GNT_D;
            A      <= 32'd0;
            DO     <= 32'd0;
            BEn    <= 4'hF;
            ST     <= ST_IDLE;
            RW     <= 1'b1;
            MRQn   <= 1'b1;
            BCYSTn <= 1'b1;
            I_D    <= 32'd0;
            D_DI   <= 32'd0;
            I_ACK  <= 1'b0;
            D_ACK  <= 1'b0;
            BUSERR <= 1'b0;
`ifdef V810_BUS_ARB_RR_EN
            rr_pri <= GNT_D;
`endif
        end else if (CE) begin
            state  <= state_nx;
            owner  <= owner_nx;
            A      <= a_nx;
            DO     <= do_nx;
            BEn    <= ben_nx;
            ST     <= st_nx;
            RW     <= rw_nx;
            MRQn   <= mrq_nx;
            BCYSTn <= bcyst_nx;
            I_D    <= id_nx;
            D_DI   <= ddi_nx;
            I_ACK  <= iack_nx;
            D_ACK  <= dack_nx;
            BUSERR <= berr_nx;
`ifdef V810_BUS_ARB_RR_EN
            rr_pri <= rr_nx;
`endif
        end
    end

endmodule

// File: tb/tb_v810_bus_arb.sv
// Self-checking bench for v810_bus_arb: directed table, corner sequences, randomized rounds vs a transaction model.
`timescale 1ns/1ps
module tb_v810_bus_arb;
    import v810_bus_pkg::*;

    localparam int TO = 15;

    logic        CLK = 1'b0;
    logic        RESn, CE;
    logic        I_REQ, I_ACK, D_REQ, D_WR, D_ACK, BUSERR;
    logic [31:0] I_A, I_D, D_A, D_DO, D_DI, A, DO, DI;
    logic [3:0]  D_BEn, BEn;
    logic [1:0]  ST;
    logic        MRQn, RW, BCYSTn, READYn;

    always #5 CLK = ~CLK;

    v810_bus_arb #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RESn(RESn), .CE(CE),
        .I_REQ(I_REQ), .I_A(I_A), .I_D(I_D), .I_ACK(I_ACK),
        .D_REQ(D_REQ), .D_A(D_A), .D_WR(D_WR), .D_BEn(D_BEn), .D_DO(D_DO),
        .D_DI(D_DI), .D_ACK(D_ACK), .BUSERR(BUSERR),
        .A(A), .DO(DO), .DI(DI), .BEn(BEn), .ST(ST),
        .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(READYn)
    );

    // Bus-side memory with programmable wait states per access type.
    logic [31:0] bus_mem [0:255];
    int          wait_i, wait_d, rcnt;
    logic        bus_t2;
    assign bus_t2 = !MRQn && BCYSTn;
    assign DI     = bus_mem[A[9:2]];
    always_comb READYn = !(bus_t2 && (rcnt >= ((ST == ST_DATA) ? wait_d : wait_i)));

    always @(posedge CLK) begin
        if (bus_t2 && !READYn && !RW)
            for (int b = 0; b < 4; b++)
                if (!BEn[b]) bus_mem[A[9:2]][8*b +: 8] <= DO[8*b +: 8];
        rcnt <= bus_t2 ? rcnt + 1 : 0;
    end

    // Transaction records and bookkeeping.
    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  ben;
        logic [31:0] wdat;
        int          waits;
    } acc_t;

    typedef struct {
        int          t1;
        int          cyc;
        bit          err;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        acc_t a;
        exp_t x;
    } vec_t;

    int          nvec = 0;
    int          errs = 0;
    logic [31:0] mdl_mem [0:255];
    bit          mdl_pri_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit is_d, input bit wr, input logic [31:0] addr,
                                input logic [3:0] ben, input logic [31:0] wdat, input int waits,
                                input int cyc, input bit err, input logic [31:0] dat);
        vec_t v;
        v.a.is_d = is_d; v.a.wr = wr; v.a.addr = addr; v.a.ben = ben;
        v.a.wdat = wdat; v.a.waits = waits;
        v.x.t1 = 1; v.x.cyc = cyc; v.x.err = err; v.x.dat = dat;
        return v;
    endfunction

    task automatic mdl_write(input acc_t a);
        for (int b = 0; b < 4; b++)
            if (!a.ben[b]) mdl_mem[a.addr[9:2]][8*b +: 8] = a.wdat[8*b +: 8];
    endtask

    // One access served starting with its T1 in cycle t1.
    task automatic mdl_serve(input acc_t a, input int t1, output exp_t x);
        x.t1  = t1;
        x.err = (a.waits > TO);
        x.cyc = t1 + 2 + (x.err ? TO : a.waits);
        x.dat = 32'd0;
        if (!a.wr && !x.err) x.dat = mdl_mem[a.addr[9:2]];
        if (a.wr && !x.err) mdl_write(a);
    endtask

    task automatic mdl_predict(input bit hi, input bit hd, input acc_t ai, input acc_t ad,
                               output exp_t xi, output exp_t xd);
        bit d_first;
        xi = '{0, 0, 0, 32'd0};
        xd = '{0, 0, 0, 32'd0};
`ifdef V810_BUS_ARB_RR_EN
        d_first = mdl_pri_d;
`else
        d_first = 1'b1;
`endif
        if (hi && hd) begin
            if (d_first) begin
                mdl_serve(ad, 1, xd); mdl_serve(ai, xd.cyc, xi); mdl_pri_d = 1'b1;
            end else begin
                mdl_serve(ai, 1, xi); mdl_serve(ad, xi.cyc, xd); mdl_pri_d = 1'b0;
            end
        end else if (hd) begin
            mdl_serve(ad, 1, xd); mdl_pri_d = 1'b0;
        end else if (hi) begin
            mdl_serve(ai, 1, xi); mdl_pri_d = 1'b1;
        end
    endtask

    // Drive one round from a negedge and check every ACK against expectations.
    task automatic do_round(input bit hi, input bit hd, input acc_t ai, input acc_t ad,
                            input exp_t xi, input exp_t xd);
        bit gi, gd, mrq_gap;
        int last;
        gi = !hi; gd = !hd; mrq_gap = 1'b0;
        last = 0;
        if (hi && xi.cyc > last) last = xi.cyc;
        if (hd && xd.cyc > last) last = xd.cyc;
        wait_i = ai.waits; wait_d = ad.waits;
        I_REQ = hi; I_A = ai.addr;
        D_REQ = hd; D_A = ad.addr; D_WR = ad.wr; D_BEn = ad.ben; D_DO = ad.wdat;
        for (int n = 1; n <= last + 1 && n <= 100; n++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (hi && n == xi.t1)
                chk("i_bus_t1", {MRQn, BCYSTn, ST, RW, BEn, A},
                    {1'b0, 1'b0, ST_IFETCH, 1'b1, 4'h0, ai.addr & 32'hFFFF_FFFC});
            if (hd && n == xd.t1) begin
                chk("d_bus_t1", {MRQn, BCYSTn, ST, RW, BEn, A},
                    {1'b0, 1'b0, ST_DATA, ~ad.wr, ad.ben, ad.addr & 32'hFFFF_FFFC});
                if (ad.wr) chk("d_do_t1", DO, ad.wdat);
            end
            if (hi && hd && n < last && MRQn) mrq_gap = 1'b1;
            if (I_ACK) begin
                if (gi) chk("i_ack_spurious", 1, 0);
                else begin
                    chk("i_ack_cyc", n, xi.cyc);
                    chk("i_d", I_D, xi.dat);
                    chk("i_buserr", BUSERR, xi.err);
                    gi = 1'b1; I_REQ = 1'b0;
                end
            end
            if (D_ACK) begin
                if (gd) chk("d_ack_spurious", 1, 0);
                else begin
                    chk("d_ack_cyc", n, xd.cyc);
                    if (!ad.wr) chk("d_di", D_DI, xd.dat);
                    chk("d_buserr", BUSERR, xd.err);
                    gd = 1'b1; D_REQ = 1'b0;
                end
            end
        end
        if (!gi) chk("i_ack_timeout", 0, 1);
        if (!gd) chk("d_ack_timeout", 0, 1);
        if (hi && hd) chk("mrq_back_to_back", mrq_gap, 0);
        I_REQ = 1'b0; D_REQ = 1'b0;
    endtask

    task automatic mdl_mem_init();
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 32'd0;
            mdl_mem[i] = 32'd0;
        end
        bus_mem[65] = 32'h1234_5678;
        mdl_mem[65] = 32'h1234_5678;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", nvec);
        $fatal(1);
    end

    vec_t tbl [9];
    acc_t ai, ad, none;
    exp_t xi, xd, xnone;

    initial begin
        none  = '{0, 0, 32'd0, 4'hF, 32'd0, 0};
        xnone = '{0, 0, 0, 32'd0};
        mdl_mem_init();
        mdl_pri_d = 1'b1;
        wait_i = 0; wait_d = 0;
        RESn = 1'b0; CE = 1'b1;
        I_REQ = 0; I_A = 0; D_REQ = 0; D_A = 0; D_WR = 0; D_BEn = 4'hF; D_DO = 0;
        repeat (3) @(negedge CLK);

        // Reset state
        chk("rst_ctrl", {MRQn, BCYSTn, RW, BEn, ST}, {1'b1, 1'b1, 1'b1, 4'hF, ST_IDLE});
        chk("rst_a", A, 32'd0);
        chk("rst_do", DO, 32'd0);
        chk("rst_acks", {I_ACK, D_ACK, BUSERR}, 3'b000);
        chk("rst_rdata", {I_D, D_DI}, 64'd0);
        RESn = 1'b1;

        //          is_d wr  addr          ben    wdat           waits cyc err dat
        tbl[0] = mk(0,   0,  32'h0000_0104, 4'h0, 32'd0,         0,    3,  0, 32'h1234_5678);
        tbl[1] = mk(1,   1,  32'h0000_0070, 4'h0, 32'd9,         0,    3,  0, 32'd0);
        tbl[2] = mk(1,   0,  32'h0000_0071, 4'h0, 32'd0,         0,    3,  0, 32'd9);
        tbl[3] = mk(1,   1,  32'h0000_0070, 4'hA, 32'hAABB_CCDD, 2,    5,  0, 32'd0);
        tbl[4] = mk(1,   0,  32'h0000_0070, 4'h0, 32'd0,         3,    6,  0, 32'h00BB_00DD);
        tbl[5] = mk(0,   0,  32'h0000_0104, 4'h0, 32'd0,         15,   18, 0, 32'h1234_5678);
        tbl[6] = mk(1,   0,  32'h0000_0070, 4'h0, 32'd0,         255,  18, 1, 32'd0);
        tbl[7] = mk(1,   1,  32'h0000_0080, 4'h0, 32'h55,        16,   18, 1, 32'd0);
        tbl[8] = mk(1,   0,  32'h0000_0080, 4'h0, 32'd0,         0,    3,  0, 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].a.is_d) begin
                do_round(0, 1, none, tbl[i].a, xnone, tbl[i].x);
                mdl_pri_d = 1'b0;
            end else begin
                do_round(1, 0, tbl[i].a, none, tbl[i].x, xnone);
                mdl_pri_d = 1'b1;
            end
            if (tbl[i].a.wr && !tbl[i].x.err) mdl_write(tbl[i].a);
        end

        // Reset asserted in the middle of T2: bus released at once, no ACK afterwards.
        wait_i = 5; I_A = 32'h200; I_REQ = 1'b1;
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        RESn = 1'b0;
        #1;
        chk("rst_mid_mrq", MRQn, 1'b1);
        chk("rst_mid_bcyst_st", {BCYSTn, ST}, {1'b1, ST_IDLE});
        I_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        RESn = 1'b1;
        mdl_pri_d = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            repeat (6) begin
                @(negedge CLK);
                if (I_ACK || D_ACK || !MRQn) seen = 1'b1;
            end
            chk("rst_mid_no_ack", seen, 1'b0);
        end
        ai = '{0, 0, 32'h0000_0104, 4'h0, 32'd0, 0};
        mdl_predict(1, 0, ai, none, xi, xd);
        do_round(1, 0, ai, none, xi, xd);

        // Simultaneous requests: data first, fetch back-to-back two cycles later.
        ai = '{0, 0, 32'h0000_0104, 4'h0, 32'd0, 0};
        ad = '{1, 1, 32'h0000_0040, 4'h0, 32'h77, 0};
        xd = '{1, 3, 0, 32'd0};
        xi = '{3, 5, 0, 32'h1234_5678};
        do_round(1, 1, ai, ad, xi, xd);
        mdl_write(ad);
        mdl_pri_d = 1'b1;

        // CE low for three cycles during T1 stretches the access by three cycles.
        wait_i = 0; I_A = 32'h104; I_REQ = 1'b1;
        begin
            int ack_at;
            bit frozen_ok;
            ack_at = 0; frozen_ok = 1'b1;
            for (int n = 1; n <= 12; n++) begin
                @(posedge CLK); @(negedge CLK);
                if (n == 1) CE = 1'b0;
                if (n >= 2 && n <= 4 && (BCYSTn || MRQn)) frozen_ok = 1'b0;
                if (n == 4) CE = 1'b1;
                if (I_ACK && ack_at == 0) begin ack_at = n; I_REQ = 1'b0; end
            end
            chk("ce_frozen_t1", frozen_ok, 1'b1);
            chk("ce_ack_cyc", ack_at, 6);
            I_REQ = 1'b0;
        end
        mdl_pri_d = 1'b1;

        // Randomized rounds against the transaction model.
        for (int r = 0; r < 40; r++) begin
            int kind;
            kind = $urandom_range(0, 2);
            ai.is_d = 0; ai.wr = 0; ai.ben = 4'h0; ai.wdat = 0;
            ai.addr = {$urandom} ;
            ai.waits = ($urandom_range(0, 7) == 0) ? 14 + $urandom_range(0, 4) : $urandom_range(0, 4);
            ad.is_d = 1; ad.wr = $urandom_range(0, 1);
            ad.addr = $urandom;
            ad.addr[9:8] = 2'b00;
            ad.ben = 4'($urandom);
            ad.wdat = $urandom;
            ad.waits = ($urandom_range(0, 7) == 0) ? 14 + $urandom_range(0, 4) : $urandom_range(0, 4);
            mdl_predict(kind != 1, kind != 0, ai, ad, xi, xd);
            do_round(kind != 1, kind != 0, ai, ad, xi, xd);
        end

        begin
            bit mem_ok;
            mem_ok = 1'b1;
            for (int i = 0; i < 256; i++)
                if (bus_mem[i] !== mdl_mem[i]) mem_ok = 1'b0;
            chk("final_memory_image", mem_ok, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
